// File: rtl/mul_div_pkg.sv
// Shared encodings and sign helpers for the sequential multiply/divide unit and the ALU.
package mul_div_pkg;

  // Widest vector the sign helper handles; covers a 2*WIDTH product for WIDTH up to 64.
  localparam int unsigned MAX_W = 128;

  localparam logic [1:0] OP_MULS = 2'b00;
  localparam logic [1:0] OP_MULU = 2'b01;
  localparam logic [1:0] OP_DIVS = 2'b10;
  localparam logic [1:0] OP_DIVU = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ITER  = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Conditional two's-complement negate. Callers zero-extend into MAX_W and truncate the
  // result back; the low bits are exact, so this gives neg() and abs() at any width.
  function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] x, input logic neg);
    return neg ? (~x + MAX_W'(1)) : x;
  endfunction

endpackage

// File: rtl/mul_div_seq.sv
// Multi-cycle signed/unsigned multiply (shift-add) and divide (restoring), one bit per cycle.
module mul_div_seq
  import mul_div_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z_high,
  output logic [WIDTH-1:0] z_low,
  output logic             div_by_zero
);

  localparam int unsigned W2 = 2 * WIDTH;

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   ra_q, ra_d;        // raw operands captured with the accepted start
  logic [WIDTH-1:0]   rb_q, rb_d;
  logic               sa_q, sa_d;        // operand signs (zero in unsigned modes)
  logic               sb_q, sb_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;    // multiplicand (MUL) or divisor (DIV) magnitude
  logic [W2-1:0]      acc_q, acc_d;      // MUL {hi, multiplier}; DIV {rem, quot}
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   z_high_q, z_high_d;
  logic [WIDTH-1:0]   z_low_q, z_low_d;
  logic               dbz_q, dbz_d;

  logic               is_div_c;
  logic               sign_a_c, sign_b_c;
  logic [WIDTH-1:0]   mag_a_c, mag_b_c;
  logic [WIDTH:0]     mul_sum_c;
  logic [W2-1:0]      mul_next_c;
  logic [WIDTH:0]     rem_sh_c;
  logic               div_ge_c;
  logic [W2-1:0]      div_next_c;
  logic [W2-1:0]      prod_fix_c;
  logic [WIDTH-1:0]   quot_fix_c, rem_fix_c;

  // Operand decode and one iteration step of each algorithm.
  always_comb begin
    is_div_c   = op_q[1];
    sign_a_c   = ~op_q[0] & ra_q[WIDTH-1];
    sign_b_c   = ~op_q[0] & rb_q[WIDTH-1];
    mag_a_c    = WIDTH'(cond_neg(MAX_W'(ra_q), sign_a_c));
    mag_b_c    = WIDTH'(cond_neg(MAX_W'(rb_q), sign_b_c));

    mul_sum_c  = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : WIDTH'(0))};
    mul_next_c = {mul_sum_c, acc_q[WIDTH-1:1]};

    rem_sh_c   = acc_q[W2-1:WIDTH-1];
    div_ge_c   = (rem_sh_c >= {1'b0, opnd_q});
    div_next_c = div_ge_c ? {WIDTH'(rem_sh_c - {1'b0, opnd_q}), acc_q[WIDTH-2:0], 1'b1}
                          : {rem_sh_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    prod_fix_c = W2'(cond_neg(MAX_W'(acc_q), sa_q ^ sb_q));
    quot_fix_c = WIDTH'(cond_neg(MAX_W'(acc_q[WIDTH-1:0]), sa_q ^ sb_q));
    rem_fix_c  = WIDTH'(cond_neg(MAX_W'(acc_q[W2-1:WIDTH]), sa_q));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    z_high_d = z_high_q;
    z_low_d  = z_low_q;
    dbz_d    = dbz_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          busy_d  = 1'b1;
          op_d    = op;
          ra_d    = a;
          rb_d    = b;
        end
      end
      S_LOAD: begin
        sa_d     = sign_a_c;
        sb_d     = sign_b_c;
        z_high_d = '0;
        z_low_d  = '0;
        dbz_d    = 1'b0;
        if (is_div_c && (rb_q == '0)) begin
          // Divide by zero skips the iteration entirely.
          state_d  = S_DONE;
          done_d   = 1'b1;
          z_high_d = ra_q;
          z_low_d  = '1;
          dbz_d    = 1'b1;
        end else begin
          state_d = S_ITER;
          cnt_d   = CNT_W'(WIDTH);
          opnd_d  = is_div_c ? mag_b_c : mag_a_c;
          acc_d   = is_div_c ? {WIDTH'(0), mag_a_c} : {WIDTH'(0), mag_b_c};
        end
      end
      S_ITER: begin
        acc_d = is_div_c ? div_next_c : mul_next_c;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_FIXUP;
        end
      end
      S_FIXUP: begin
        state_d = S_DONE;
        done_d  = 1'b1;
        if (is_div_c) begin
          z_high_d = rem_fix_c;
          z_low_d  = quot_fix_c;
        end else begin
          z_high_d = prod_fix_c[W2-1:WIDTH];
          z_low_d  = prod_fix_c[WIDTH-1:0];
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      z_high_q <= '0;
      z_low_q  <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      z_high_q <= z_high_d;
      z_low_q  <= z_low_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign z_high      = z_high_q;
  assign z_low       = z_low_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_seq.sv
// Self-checking bench for mul_div_seq (WIDTH=32) with a result scoreboard.
module tb_mul_div_seq;

  localparam logic [1:0] MULS = 2'b00;
  localparam logic [1:0] MULU = 2'b01;
  localparam logic [1:0] DIVS = 2'b10;
  localparam logic [1:0] DIVU = 2'b11;

  typedef struct {
    logic [31:0] zh;
    logic [31:0] zl;
    logic        dbz;
  } res_t;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] z_high, z_low;

  int   n_checks = 0;
  int   n_pass   = 0;
  res_t exp_q[$];

  mul_div_seq #(.WIDTH(32)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .z_high(z_high), .z_low(z_low), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference arithmetic, independent of the iterative algorithm.
  function automatic res_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    res_t r;
    logic signed [63:0] sx, sy, p;
    logic [63:0] up;
    int qi, ri;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    r.dbz = 1'b0;
    case (o)
      MULS: begin p = sx * sy; r.zh = p[63:32]; r.zl = p[31:0]; end
      MULU: begin up = {32'd0, x} * {32'd0, y}; r.zh = up[63:32]; r.zl = up[31:0]; end
      default: begin
        if (y == 32'd0) begin
          r.zh = x; r.zl = 32'hFFFF_FFFF; r.dbz = 1'b1;
        end else if (o == DIVS && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          r.zh = 32'd0; r.zl = 32'h8000_0000;
        end else if (o == DIVS) begin
          qi = $signed(x) / $signed(y);
          ri = $signed(x) % $signed(y);
          r.zh = ri; r.zl = qi;
        end else begin
          r.zh = x % y; r.zl = x / y;
        end
      end
    endcase
    return r;
  endfunction

  // Issue one operation, optionally re-pulse start mid-flight, wait (bounded) for done and score it.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit at_neg, input int repulse_cyc,
                        output int lat, output int busy_err);
    res_t e;
    if (!at_neg) @(negedge clk);
    clr = 1'b0; op = o; a = x; b = y; start = 1'b1;
    exp_q.push_back(model(o, x, y));
    @(posedge clk);
    lat = -1;
    busy_err = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 2) begin a = $urandom; b = $urandom; op = 2'($urandom); end
      if (repulse_cyc != 0 && c == repulse_cyc) begin
        start = 1'b1; op = MULU; a = 32'd7; b = 32'd9;
      end
      if (repulse_cyc != 0 && c == repulse_cyc + 1) start = 1'b0;
      if (busy !== 1'b1) busy_err++;
      if (done === 1'b1) begin
        lat = c;
        e = exp_q.pop_front();
        n_checks++;
        if (z_high !== e.zh || z_low !== e.zl || div_by_zero !== e.dbz)
          $display("FAIL result op=%0d a=%h b=%h got zh=%h zl=%h dbz=%b want zh=%h zl=%h dbz=%b",
                   o, x, y, z_high, z_low, div_by_zero, e.zh, e.zl, e.dbz);
        else n_pass++;
        break;
      end
    end
    start = 1'b0;
    if (lat < 0) void'(exp_q.pop_back());
  endtask

  task automatic test_reset();
    clr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, done, div_by_zero} !== 3'b000) $display("FAIL reset_flags got %b want 000", {busy, done, div_by_zero});
    else n_pass++;
    n_checks++;
    if ({z_high, z_low} !== 64'd0) $display("FAIL reset_z got %h want 0", {z_high, z_low});
    else n_pass++;
    clr = 1'b0;
  endtask

  task automatic test_mul();
    int lat, berr;
    run_op(MULS, 32'hFFFF_FFF9, 32'd6, 1'b0, 0, lat, berr);
    n_checks++;
    if (lat !== 35) $display("FAIL muls_latency got %0d want 35", lat); else n_pass++;
    n_checks++;
    if (berr !== 0) $display("FAIL muls_busy low cycles got %0d want 0", berr); else n_pass++;
    n_checks++;
    if ({z_high, z_low} !== 64'hFFFF_FFFF_FFFF_FFD6) $display("FAIL muls_value got %h want FFFFFFFFFFFFFFD6", {z_high, z_low});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) $display("FAIL muls_after_done got busy,done=%b want 00", {busy, done}); else n_pass++;
    run_op(MULU, 32'hFFFF_FFFF, 32'd2, 1'b0, 0, lat, berr);
    n_checks++;
    if ({z_high, z_low} !== 64'h0000_0001_FFFF_FFFE) $display("FAIL mulu_value got %h want 00000001FFFFFFFE", {z_high, z_low});
    else n_pass++;
    run_op(MULS, 32'hFFFF_FFFF, 32'd2, 1'b0, 0, lat, berr);
    n_checks++;
    if ({z_high, z_low} !== 64'hFFFF_FFFF_FFFF_FFFE) $display("FAIL muls_neg1x2 got %h want FFFFFFFFFFFFFFFE", {z_high, z_low});
    else n_pass++;
  endtask

  task automatic test_div();
    int lat, berr;
    run_op(DIVS, 32'hFFFF_FFEF, 32'd5, 1'b0, 0, lat, berr);
    n_checks++;
    if ({z_high, z_low} !== 64'hFFFF_FFFE_FFFF_FFFD) $display("FAIL divs_value got %h want FFFFFFFEFFFFFFFD", {z_high, z_low});
    else n_pass++;
    n_checks++;
    if (lat !== 35) $display("FAIL divs_latency got %0d want 35", lat); else n_pass++;
    run_op(DIVU, 32'd17, 32'd5, 1'b0, 0, lat, berr);
    n_checks++;
    if ({z_high, z_low} !== 64'h0000_0002_0000_0003) $display("FAIL divu_value got %h want 0000000200000003", {z_high, z_low});
    else n_pass++;
  endtask

  task automatic test_div_zero();
    int lat, berr;
    run_op(DIVU, 32'd100, 32'd0, 1'b0, 0, lat, berr);
    n_checks++;
    if (lat !== 2) $display("FAIL dbz_latency got %0d want 2", lat); else n_pass++;
    n_checks++;
    if (berr !== 0) $display("FAIL dbz_busy low cycles got %0d want 0", berr); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({div_by_zero, z_high, z_low} !== {1'b1, 32'd100, 32'hFFFF_FFFF})
      $display("FAIL dbz_hold got dbz=%b zh=%h zl=%h want 1 00000064 FFFFFFFF", div_by_zero, z_high, z_low);
    else n_pass++;
    run_op(MULU, 32'd3, 32'd4, 1'b0, 0, lat, berr);
    n_checks++;
    if ({div_by_zero, z_low} !== {1'b0, 32'd12}) $display("FAIL dbz_clear got dbz=%b zl=%h want 0 0000000c", div_by_zero, z_low);
    else n_pass++;
    run_op(DIVS, 32'h8000_0005, 32'd0, 1'b0, 0, lat, berr);
    n_checks++;
    if (z_high !== 32'h8000_0005) $display("FAIL dbz_signed_raw got %h want 80000005", z_high); else n_pass++;
  endtask

  task automatic test_min_cases();
    int lat, berr;
    run_op(DIVS, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, lat, berr);
    n_checks++;
    if ({div_by_zero, z_high, z_low} !== {1'b0, 32'd0, 32'h8000_0000})
      $display("FAIL divs_min_neg1 got dbz=%b zh=%h zl=%h want 0 00000000 80000000", div_by_zero, z_high, z_low);
    else n_pass++;
    run_op(MULS, 32'h8000_0000, 32'h8000_0000, 1'b0, 0, lat, berr);
    n_checks++;
    if ({z_high, z_low} !== 64'h4000_0000_0000_0000) $display("FAIL muls_min_min got %h want 4000000000000000", {z_high, z_low});
    else n_pass++;
  endtask

  task automatic test_ignore_restart();
    int lat, berr, extra;
    run_op(MULU, 32'd5, 32'd5, 1'b0, 10, lat, berr);
    n_checks++;
    if (z_low !== 32'd25 || lat !== 35) $display("FAIL restart_ignored got zl=%0d lat=%0d want 25 35", z_low, lat);
    else n_pass++;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    n_checks++;
    if (extra !== 0) $display("FAIL restart_queued got %0d active cycles want 0", extra); else n_pass++;
  endtask

  task automatic test_clr();
    int lat, berr, dn;
    @(negedge clk);
    op = MULU; a = 32'h1234_5678; b = 32'd9; start = 1'b1;
    @(posedge clk);
    dn = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (done === 1'b1) dn++;
      if (c == 20) clr = 1'b1;
    end
    @(negedge clk);
    n_checks++;
    if ({busy, done, div_by_zero, dn[0]} !== 4'b0000) $display("FAIL clr_flags got busy,done,dbz=%b early_done=%0d want 000 0", {busy, done, div_by_zero}, dn);
    else n_pass++;
    n_checks++;
    if ({z_high, z_low} !== 64'd0) $display("FAIL clr_z got %h want 0", {z_high, z_low}); else n_pass++;
    run_op(MULU, 32'd6, 32'd7, 1'b1, 0, lat, berr);
    n_checks++;
    if (lat !== 35 || z_low !== 32'd42) $display("FAIL clr_restart got lat=%0d zl=%0d want 35 42", lat, z_low);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int first, second, lat, berr;
    logic [1:0] o;
    logic [31:0] x, y;
    res_t e;
    @(negedge clk);
    op = MULU; a = 32'd1000; b = 32'd3000; start = 1'b1;
    exp_q.push_back(model(MULU, 32'd1000, 32'd3000));
    exp_q.push_back(model(MULU, 32'd1000, 32'd3000));
    @(posedge clk);
    first = -1; second = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        e = exp_q.pop_front();
        n_checks++;
        if (z_low !== e.zl || z_high !== e.zh) $display("FAIL b2b_result got %h want %h", {z_high, z_low}, {e.zh, e.zl});
        else n_pass++;
        if (first < 0) first = c;
        else begin second = c; break; end
      end
    end
    start = 1'b0;
    exp_q.delete();
    n_checks++;
    if (first !== 35 || second - first !== 36) $display("FAIL b2b_timing got first=%0d gap=%0d want 35 36", first, second - first);
    else n_pass++;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      o = 2'($urandom);
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if (i == 0) y = 32'd0;
      run_op(o, x, y, 1'b0, 0, lat, berr);
      n_checks++;
      if (lat !== ((o[1] && y == 32'd0) ? 2 : 35)) $display("FAIL rand_latency op=%0d b=%h got %0d", o, y, lat);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_min_cases();
    test_ignore_restart();
    test_clr();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mul_div_seq.md
Name: mul_div_seq

Overview:
Parametrised multi-cycle multiply/divide unit that replaces the combinational MUL/DIV path inside the ALU. It takes operand A from the bus and operand B from the Y register, and iterates one bit per cycle. It produces a 2*WIDTH result for the Z high/Z low (HI/LO) registers. Signed and unsigned modes are supported, with a start/busy/done handshake so the control unit can stall.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH split into z_high/z_low
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
clr  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE
op  input  2  00 MUL signed, 01 MUL unsigned, 10 DIV signed, 11 DIV unsigned
a  input  WIDTH  multiplicand / dividend (bus)
b  input  WIDTH  multiplier / divisor (Y)
busy  output  1  high from cycle after accepted start until done cycle inclusive
done  output  1  one-cycle pulse, result valid
z_high  output  WIDTH  MUL: product[2W-1:W]; DIV: remainder
z_low  output  WIDTH  MUL: product[W-1:0]; DIV: quotient
div_by_zero  output  1  set with done when DIV and b==0; held until next accepted start

Behaviour:
- Clock is clk. Reset is clr, synchronous, active-high, and fixed as such. At reset: state IDLE, busy=0, done=0, z_high=0, z_low=0, div_by_zero=0, counter=0.
- States: IDLE -> (start) LOAD -> ITER (WIDTH cycles) -> FIXUP -> DONE -> IDLE.
  - Exception: DIV with b==0 goes LOAD -> DONE.
- LOAD:
  - latch op and the sign of each operand.
  - Signed op: latch magnitudes |a|, |b|. Unsigned op: latch raw a, b.
  - clear z outputs and div_by_zero.
- ITER, MUL: unsigned shift-add on magnitudes. Add multiplicand to the upper half when the accumulator LSB is 1, then shift right one.
- ITER, DIV: restoring divide. Shift {rem,quot} left one; trial-subtract the divisor. If the result is non-negative, keep it and set the quotient LSB.
- Counter runs WIDTH..1; it decrements each ITER cycle and exits at 1.
- FIXUP, signed MUL: negate the 2W product (two's complement) if sign(a)^sign(b).
- FIXUP, signed DIV: negate the quotient if sign(a)^sign(b); negate the remainder if sign(a).
- DONE: drive z_high/z_low, pulse done, busy=1 this cycle. Return to IDLE next cycle.
- Latency: start sampled at edge 0 -> done high in cycle WIDTH+3 (WIDTH=32: cycle 35).
  - Divide-by-zero: done in cycle 2.
- Divide-by-zero result: z_high=a (dividend, unmodified), z_low=all ones, div_by_zero=1.
- Signed DIV of MIN by -1: quotient wraps to MIN (0x80000000), remainder 0, no flag.
- Signed MUL of MIN*MIN: exact 2W result 0x40000000_00000000.
- start while busy: ignored, no queueing. Operand changes after LOAD are ignored.
- start in the DONE cycle: ignored. It is accepted in the following IDLE cycle if still asserted.
- z_high/z_low/div_by_zero hold their last result in IDLE until the next accepted start (LOAD clears them).
- clr mid-operation: all state and outputs return to reset values at that edge. No done pulse. A start on the cycle after clr is accepted normally.
- op is don't-care unless start is sampled in IDLE.

Decomposition:
- Shared package mul_div_pkg holds:
  - op encoding constants OP_MULS, OP_MULU, OP_DIVS, OP_DIVU
  - state encoding constants S_IDLE, S_LOAD, S_ITER, S_FIXUP, S_DONE
  - a neg/abs helper function, also usable by the ALU.
- No sub-module: the datapath (accumulator, counter, trial subtractor) and FSM stay in one module of about 200 lines.

Test Plan:
- MULS a=0xFFFFFFF9 (-7), b=6 -> z_high=0xFFFFFFFF, z_low=0xFFFFFFD6; done exactly 35 cycles after start; busy high cycles 1-35.
- MULU a=0xFFFFFFFF, b=2 -> z_high=0x00000001, z_low=0xFFFFFFFE. MULS of the same operands -> z_high=0xFFFFFFFF, z_low=0xFFFFFFFE.
- DIVS a=0xFFFFFFEF (-17), b=5 -> z_low=0xFFFFFFFD (-3), z_high=0xFFFFFFFE (-2). DIVU a=17, b=5 -> z_low=3, z_high=2.
- DIVU a=100, b=0 -> done in cycle 2, div_by_zero=1, z_high=100, z_low=0xFFFFFFFF. Next MULU 3*4 -> div_by_zero=0, z_low=12.
- DIVS a=0x80000000, b=0xFFFFFFFF -> z_low=0x80000000, z_high=0, div_by_zero=0.
- Start MULU 5*5. Re-pulse start with different operands at cycle 10 -> ignored, result 25. Assert clr at cycle 20 of a second op -> next cycle busy=0, z_high=z_low=0, no done. Immediate new start completes correctly.
